// File: rtl/uart_pkg.sv
// Shared UART receive-path definitions: trigger-level encodings, byte width,
// baud divisor and the character-timeout state type.
package uart_pkg;

   localparam int BYTE_W  = 8;
   localparam int DIVISOR = 286;

   typedef enum logic [1:0] {
      TRIG_1  = 2'd0,
      TRIG_4  = 2'd1,
      TRIG_8  = 2'd2,
      TRIG_14 = 2'd3
   } trig_e;

   typedef enum logic [1:0] {
      TO_IDLE,
      TO_COUNT,
      TO_EXPIRED
   } to_state_e;

   function automatic logic [4:0] trig_threshold(input logic [1:0] sel);
      case (trig_e'(sel))
         TRIG_1:  return 5'd1;
         TRIG_4:  return 5'd4;
         TRIG_8:  return 5'd8;
         default: return 5'd14;
      endcase
   endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Plain synchronous DEPTH x BYTE_W FIFO with push/pop/clear and an occupancy
// counter; the caller guarantees no push when full unless it also pops.
module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter  int DEPTH = 16,
   localparam int AW    = $clog2(DEPTH),
   localparam int LW    = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              push,
   input  logic              pop,
   input  logic [BYTE_W-1:0] wr_data,
   output logic [BYTE_W-1:0] rd_data,
   output logic [LW-1:0]     level
);

   logic [BYTE_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wr_ptr_reg;
   logic [AW-1:0]     rd_ptr_reg;
   logic [LW-1:0]     level_reg;

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr_reg] <= wr_data;
   end

   // Pointers wrap naturally; full vs. empty is decided by level_reg alone.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         level_reg  <= '0;
      end else begin
         if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
         if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
         if (push && !pop)      level_reg <= level_reg + LW'(1);
         else if (!push && pop) level_reg <= level_reg - LW'(1);
      end
   end

   // Asynchronous head read so a pushed byte is visible together with level.
   assign rd_data = (level_reg != '0) ? mem[rd_ptr_reg] : '0;
   assign level   = level_reg;

endmodule

// File: rtl/uart_rx_fifo_ctrl.sv
// Receive FIFO controller: rx_valid edge capture, overrun, RDA interrupt and,
// when UART_RX_TIMEOUT_EN is defined, the character-timeout interrupt.
module uart_rx_fifo_ctrl
   import uart_pkg::*;
#(
   parameter int DEPTH         = 16,
   parameter int CHAR_CLKS     = 2860,
   parameter int TIMEOUT_CHARS = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [BYTE_W-1:0] rx_data,
   input  logic              rx_valid,
   input  logic              rd_strobe,
   input  logic              lsr_rd,
   input  logic              fifo_en,
   input  logic              fifo_clr,
   input  logic [1:0]        trig_lvl,
   output logic [BYTE_W-1:0] rd_data,
   output logic              data_ready,
   output logic              overrun,
   output logic              irq_rda,
   output logic              irq_timeout,
   output logic [4:0]        level
);

   localparam int LVL_W = $clog2(DEPTH + 1);

   logic             rx_valid_reg;
   logic             fifo_en_reg;
   logic             overrun_reg;
   logic             irq_rda_reg;
   logic [LVL_W-1:0] fifo_level;
   logic             push_req, flush, full, pop, push_ok, overrun_set;

   assign push_req    = rx_valid & ~rx_valid_reg;
   assign flush       = fifo_clr | (fifo_en != fifo_en_reg);
   assign full        = fifo_en ? (fifo_level == LVL_W'(DEPTH)) : (fifo_level != '0);
   assign pop         = rd_strobe & (fifo_level != '0) & ~flush;
   // A pop frees the slot the incoming byte needs, even when full.
   assign push_ok     = push_req & ~flush & (~full | pop);
   assign overrun_set = push_req & ~flush & full & ~pop;

   uart_rx_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .clr     (flush),
      .push    (push_ok),
      .pop     (pop),
      .wr_data (rx_data),
      .rd_data (rd_data),
      .level   (fifo_level)
   );

   always_ff @(posedge clk) begin
      fifo_en_reg <= fifo_en;
      if (rst) begin
         rx_valid_reg <= 1'b0;
         overrun_reg  <= 1'b0;
         irq_rda_reg  <= 1'b0;
      end else begin
         rx_valid_reg <= rx_valid;
         if (overrun_set) overrun_reg <= 1'b1;
         else if (lsr_rd) overrun_reg <= 1'b0;
         irq_rda_reg <= fifo_en ? (level >= trig_threshold(trig_lvl)) : (level != 5'd0);
      end
   end

   assign level      = 5'(fifo_level);
   assign data_ready = (fifo_level != '0);
   assign overrun    = overrun_reg;
   assign irq_rda    = irq_rda_reg;

`ifdef UART_RX_TIMEOUT_EN
   localparam int TO_MAX = TIMEOUT_CHARS * CHAR_CLKS;
   localparam int CNT_W  = $clog2(TO_MAX + 1);

   to_state_e        state_reg, state_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic             irq_to_reg, irq_to_next;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg  <= TO_IDLE;
         cnt_reg    <= '0;
         irq_to_reg <= 1'b0;
      end else begin
         state_reg  <= state_next;
         cnt_reg    <= cnt_next;
         irq_to_reg <= irq_to_next;
      end
   end

   always_comb begin
      state_next  = state_reg;
      cnt_next    = cnt_reg;
      irq_to_next = irq_to_reg;
      if (flush || !fifo_en || fifo_level == '0) begin
         state_next  = TO_IDLE;
         cnt_next    = '0;
         irq_to_next = 1'b0;
      end else if (pop) begin
         cnt_next    = '0;
         irq_to_next = 1'b0;
         state_next  = (fifo_level == LVL_W'(1) && !push_ok) ? TO_IDLE : TO_COUNT;
      end else if (push_ok) begin
         // Restart the idle window; an already raised interrupt stays up.
         cnt_next   = '0;
         state_next = TO_COUNT;
      end else begin
         unique case (state_reg)
            TO_IDLE, TO_COUNT: begin
               cnt_next   = cnt_reg + CNT_W'(1);
               state_next = TO_COUNT;
               if (cnt_reg == CNT_W'(TO_MAX - 1)) begin
                  state_next  = TO_EXPIRED;
                  irq_to_next = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign irq_timeout = irq_to_reg;
`else
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = ^{CHAR_CLKS, TIMEOUT_CHARS};
   assign irq_timeout        = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo_ctrl.sv
// Directed self-checking bench for uart_rx_fifo_ctrl; the timeout section
// follows UART_RX_TIMEOUT_EN like the design.
module tb_uart_rx_fifo_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] rx_data;
   logic       rx_valid, rd_strobe, lsr_rd, fifo_en, fifo_clr;
   logic [1:0] trig_lvl;
   logic [7:0] rd_data;
   logic       data_ready, overrun, irq_rda, irq_timeout;
   logic [4:0] level;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   uart_rx_fifo_ctrl dut (
      .clk         (clk),
      .rst         (rst),
      .rx_data     (rx_data),
      .rx_valid    (rx_valid),
      .rd_strobe   (rd_strobe),
      .lsr_rd      (lsr_rd),
      .fifo_en     (fifo_en),
      .fifo_clr    (fifo_clr),
      .trig_lvl    (trig_lvl),
      .rd_data     (rd_data),
      .data_ready  (data_ready),
      .overrun     (overrun),
      .irq_rda     (irq_rda),
      .irq_timeout (irq_timeout),
      .level       (level)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic push_byte(input logic [7:0] b);
      rx_data  = b;
      rx_valid = 1'b1;
      tick(1);
      rx_valid = 1'b0;
      tick(1);
      $display("push %02h level=%0d overrun=%0d", b, level, overrun);
   endtask

   task automatic pop_byte();
      rd_strobe = 1'b1;
      tick(1);
      rd_strobe = 1'b0;
      $display("pop  head=%02h level=%0d", rd_data, level);
   endtask

   task automatic pulse_clr();
      fifo_clr = 1'b1;
      tick(1);
      fifo_clr = 1'b0;
      tick(1);
   endtask

   task automatic pulse_lsr();
      lsr_rd = 1'b1;
      tick(1);
      lsr_rd = 1'b0;
   endtask

   initial begin
      rst = 1'b1; rx_data = 8'h00; rx_valid = 1'b0; rd_strobe = 1'b0;
      lsr_rd = 1'b0; fifo_en = 1'b1; fifo_clr = 1'b0; trig_lvl = 2'd1;
      tick(3);
      rst = 1'b0;
      tick(1);
      chk("rst_level", 32'(level), 0);
      chk("rst_dr", 32'(data_ready), 0);
      chk("rst_ovr", 32'(overrun), 0);
      chk("rst_rda", 32'(irq_rda), 0);
      chk("rst_to", 32'(irq_timeout), 0);
      chk("rst_rd_data", 32'(rd_data), 0);

      // Three bytes, trigger 4: below threshold, read back in order.
      push_byte(8'h41); push_byte(8'h42); push_byte(8'h43);
      chk("lvl3", 32'(level), 3);
      chk("lvl3_rda", 32'(irq_rda), 0);
      chk("lvl3_dr", 32'(data_ready), 1);
      chk("head41", 32'(rd_data), 32'h41);
      pop_byte();
      chk("head42", 32'(rd_data), 32'h42);
      pop_byte();
      chk("head43", 32'(rd_data), 32'h43);
      pop_byte();
      chk("empty_dr", 32'(data_ready), 0);
      chk("empty_lvl", 32'(level), 0);
      chk("empty_rd_data", 32'(rd_data), 0);
      pop_byte();
      chk("underflow_lvl", 32'(level), 0);

      // Level-held rx_valid yields a single push.
      rx_data = 8'h55; rx_valid = 1'b1;
      tick(50);
      rx_valid = 1'b0;
      tick(1);
      chk("hold_lvl", 32'(level), 1);
      chk("hold_head", 32'(rd_data), 32'h55);
      pulse_clr();
      chk("clr_lvl", 32'(level), 0);

      // Overflow: 16 bytes then EE is dropped.
      for (int i = 0; i < 16; i++) push_byte(8'(8'h10 + i));
      chk("full_lvl", 32'(level), 16);
      chk("full_ovr0", 32'(overrun), 0);
      push_byte(8'hEE);
      chk("ovf_ovr", 32'(overrun), 1);
      chk("ovf_lvl", 32'(level), 16);
      chk("ovf_head", 32'(rd_data), 32'h10);
      pulse_clr();
      chk("clr_keeps_ovr", 32'(overrun), 1);
      pulse_lsr();
      chk("lsr_clr_ovr", 32'(overrun), 0);

      // Overrun set beats lsr_rd in the same cycle.
      for (int i = 0; i < 16; i++) push_byte(8'(8'h30 + i));
      rx_data = 8'hEF; rx_valid = 1'b1; lsr_rd = 1'b1;
      tick(1);
      rx_valid = 1'b0; lsr_rd = 1'b0;
      tick(1);
      chk("set_wins_ovr", 32'(overrun), 1);
      pulse_lsr();
      chk("lsr_clr_ovr2", 32'(overrun), 0);

      // Full + simultaneous push/pop: no overrun, new byte lands last.
      rx_data = 8'hAB; rx_valid = 1'b1; rd_strobe = 1'b1;
      tick(1);
      rx_valid = 1'b0; rd_strobe = 1'b0;
      tick(1);
      chk("pp_lvl", 32'(level), 16);
      chk("pp_ovr", 32'(overrun), 0);
      chk("pp_head", 32'(rd_data), 32'h31);
      for (int i = 0; i < 15; i++) pop_byte();
      chk("pp_last", 32'(rd_data), 32'hAB);
      chk("pp_last_lvl", 32'(level), 1);

      // 16450 mode: capacity one (mode change flushes).
      fifo_en = 1'b0;
      tick(2);
      chk("mode_flush_lvl", 32'(level), 0);
      push_byte(8'h11);
      chk("nf_rda", 32'(irq_rda), 1);
      push_byte(8'h22);
      chk("nf_ovr", 32'(overrun), 1);
      chk("nf_head", 32'(rd_data), 32'h11);
      chk("nf_lvl", 32'(level), 1);
      pulse_lsr();

      // Trigger 8.
      fifo_en = 1'b1; trig_lvl = 2'd2;
      tick(2);
      chk("mode_flush_lvl2", 32'(level), 0);
      for (int i = 0; i < 7; i++) push_byte(8'(8'h60 + i));
      chk("t8_below", 32'(irq_rda), 0);
      push_byte(8'h67);
      chk("t8_rise", 32'(irq_rda), 1);
      trig_lvl = 2'd3;
      tick(2);
      chk("t14_low", 32'(irq_rda), 0);
      trig_lvl = 2'd0;
      tick(2);
      chk("t1_high", 32'(irq_rda), 1);

      // Character timeout.
      pulse_clr();
      push_byte(8'h99);
`ifdef UART_RX_TIMEOUT_EN
      tick(11437);
      chk("to_early", 32'(irq_timeout), 0);
      tick(3);
      chk("to_fire", 32'(irq_timeout), 1);
      pop_byte();
      tick(1);
      chk("to_pop_clr", 32'(irq_timeout), 0);
      tick(12000);
      chk("to_empty", 32'(irq_timeout), 0);
`else
      tick(11500);
      chk("to_disabled", 32'(irq_timeout), 0);
      pop_byte();
`endif
      chk("to_end_lvl", 32'(level), 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
